// File: rtl/sdram_frame_scheduler.sv
// sdram_frame_scheduler
// Triple-buffer frame scheduler that sits in front of an SDRAM controller's
// write and read FIFO ports. Three frame buffers live in SDRAM. One is being
// written, one is being displayed, and the third is either spare or holds a
// completed frame that has not been read yet.
//
// Writer frame-end events swap the write and spare buffers. Reader frame-start
// events take the newest complete frame, or repeat the current one if no new
// frame is ready. The writer never stalls.
//
// Ports:
//   i_clk              controller clock (SDRAM controller REF_CLK domain)
//   i_rst              asynchronous active-high reset
//   i_wr_frame_end     1-cycle pulse, writer finished its frame
//   i_rd_frame_start   1-cycle pulse, display vsync
//   o_wr_load          write-side address load / FIFO clear
//   o_wr_min_addr      write buffer start word address
//   o_wr_max_addr      write buffer end word address
//   o_rd_load          read-side address load / FIFO clear
//   o_rd_min_addr      read buffer start word address
//   o_rd_max_addr      read buffer end word address
//   o_wr_buf           index of the buffer being written
//   o_rd_buf           index of the buffer being read
//   o_frame_ready      spare buffer holds a completed, unread frame
//   o_drop_cnt         frames overwritten before being read (saturating)
//   o_repeat_cnt       reader frame starts with no new frame (saturating)
module sdram_frame_scheduler #(
  parameter int unsigned ASIZE       = 21,
  parameter int unsigned BUF_BASE    = 0,
  parameter int unsigned BUF_STRIDE  = 32'h0008_0000,
  parameter int unsigned FRAME_WORDS = 384000,
  parameter int unsigned LOAD_CYCLES = 4
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_wr_frame_end,
  input  logic             i_rd_frame_start,
  output logic             o_wr_load,
  output logic [ASIZE-1:0] o_wr_min_addr,
  output logic [ASIZE-1:0] o_wr_max_addr,
  output logic             o_rd_load,
  output logic [ASIZE-1:0] o_rd_min_addr,
  output logic [ASIZE-1:0] o_rd_max_addr,
  output logic [1:0]       o_wr_buf,
  output logic [1:0]       o_rd_buf,
  output logic             o_frame_ready,
  output logic [15:0]      o_drop_cnt,
  output logic [15:0]      o_repeat_cnt
);

  // Buffer start addresses; the index-to-address multiply is a constant mux.
  localparam logic [ASIZE-1:0] MIN0      = ASIZE'(BUF_BASE);
  localparam logic [ASIZE-1:0] MIN1      = ASIZE'(BUF_BASE + BUF_STRIDE);
  localparam logic [ASIZE-1:0] MIN2      = ASIZE'(BUF_BASE + 2 * BUF_STRIDE);
  localparam logic [ASIZE-1:0] FSZ       = ASIZE'(FRAME_WORDS);
  localparam logic [3:0]       LOAD_INIT = 4'(LOAD_CYCLES);

  function automatic logic [ASIZE-1:0] buf_min(input logic [1:0] idx);
    case (idx)
      2'd1:    return MIN1;
      2'd2:    return MIN2;
      default: return MIN0;
    endcase
  endfunction

  // Init / run FSM: the first edge after reset release fires both loads.
  typedef enum logic {StInit, StRun} state_e;

  state_e r_state;
  state_e w_state_next;
  logic   w_init;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state <= StInit;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      StInit:  w_state_next = StRun;
      StRun:   w_state_next = StRun;
      default: w_state_next = StInit;
    endcase
  end

  always_comb begin
    w_init = (r_state == StInit);
  end

  // Buffer indices and ready flag.
  logic [1:0]  r_wr;
  logic [1:0]  r_rd;
  logic        r_ready;
  logic [1:0]  w_spare;
  logic [1:0]  w_spare_mid;
  logic [1:0]  w_wr_next;
  logic [1:0]  w_rd_next;
  logic        w_ready_next;
  logic        w_drop_inc;
  logic        w_rep_inc;
  logic        w_wr_reload;
  logic        w_rd_reload;
  logic [3:0]  r_wr_cnt;
  logic [3:0]  r_rd_cnt;
  logic [3:0]  w_wr_cnt_next;
  logic [3:0]  w_rd_cnt_next;
  logic        r_wr_load;
  logic        r_rd_load;
  logic [ASIZE-1:0] r_wr_min;
  logic [ASIZE-1:0] r_wr_max;
  logic [ASIZE-1:0] r_rd_min;
  logic [ASIZE-1:0] r_rd_max;
  logic [15:0] r_drop_cnt;
  logic [15:0] r_rep_cnt;

  // Indices are a permutation of {0,1,2}, so spare is what is left over.
  assign w_spare = 2'd3 - r_wr - r_rd;

  // Simultaneous events resolve as the write swap followed by the read swap.
  always_comb begin
    w_wr_next    = r_wr;
    w_rd_next    = r_rd;
    w_ready_next = r_ready;
    w_spare_mid  = w_spare;
    w_drop_inc   = 1'b0;
    w_rep_inc    = 1'b0;
    if (i_wr_frame_end) begin
      w_wr_next    = w_spare;
      w_spare_mid  = r_wr;
      w_drop_inc   = r_ready;
      w_ready_next = 1'b1;
    end
    if (i_rd_frame_start) begin
      if (w_ready_next) begin
        w_rd_next    = w_spare_mid;
        w_ready_next = 1'b0;
      end else begin
        w_rep_inc = 1'b1;
      end
    end
  end

  // A repeat also reloads the read side so the FIFO restarts the same buffer.
  assign w_wr_reload = w_init | i_wr_frame_end;
  assign w_rd_reload = w_init | i_rd_frame_start;

  always_comb begin
    w_wr_cnt_next = r_wr_cnt;
    w_rd_cnt_next = r_rd_cnt;
    if (w_wr_reload) begin
      w_wr_cnt_next = LOAD_INIT;
    end else if (r_wr_cnt != 4'd0) begin
      w_wr_cnt_next = r_wr_cnt - 4'd1;
    end
    if (w_rd_reload) begin
      w_rd_cnt_next = LOAD_INIT;
    end else if (r_rd_cnt != 4'd0) begin
      w_rd_cnt_next = r_rd_cnt - 4'd1;
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_wr       <= 2'd0;
      r_rd       <= 2'd1;
      r_ready    <= 1'b0;
      r_wr_cnt   <= 4'd0;
      r_rd_cnt   <= 4'd0;
      r_wr_load  <= 1'b0;
      r_rd_load  <= 1'b0;
      r_wr_min   <= MIN0;
      r_wr_max   <= MIN0 + FSZ;
      r_rd_min   <= MIN1;
      r_rd_max   <= MIN1 + FSZ;
      r_drop_cnt <= 16'd0;
      r_rep_cnt  <= 16'd0;
    end else begin
      r_wr      <= w_wr_next;
      r_rd      <= w_rd_next;
      r_ready   <= w_ready_next;
      r_wr_cnt  <= w_wr_cnt_next;
      r_rd_cnt  <= w_rd_cnt_next;
      // Load rises on the same edge as the new address.
      r_wr_load <= (w_wr_cnt_next != 4'd0);
      r_rd_load <= (w_rd_cnt_next != 4'd0);
      r_wr_min  <= buf_min(w_wr_next);
      r_wr_max  <= buf_min(w_wr_next) + FSZ;
      r_rd_min  <= buf_min(w_rd_next);
      r_rd_max  <= buf_min(w_rd_next) + FSZ;
      if (w_drop_inc && (r_drop_cnt != 16'hFFFF)) begin
        r_drop_cnt <= r_drop_cnt + 16'd1;
      end
      if (w_rep_inc && (r_rep_cnt != 16'hFFFF)) begin
        r_rep_cnt <= r_rep_cnt + 16'd1;
      end
    end
  end

  assign o_wr_load     = r_wr_load;
  assign o_rd_load     = r_rd_load;
  assign o_wr_min_addr = r_wr_min;
  assign o_wr_max_addr = r_wr_max;
  assign o_rd_min_addr = r_rd_min;
  assign o_rd_max_addr = r_rd_max;
  assign o_wr_buf      = r_wr;
  assign o_rd_buf      = r_rd;
  assign o_frame_ready = r_ready;
  assign o_drop_cnt    = r_drop_cnt;
  assign o_repeat_cnt  = r_rep_cnt;

endmodule

// File: doc/sdram_frame_scheduler.md
Name: sdram_frame_scheduler

Overview:
- Triple-buffer frame scheduler in front of the SDRAM controller's write and read FIFO ports.
- Keeps three frame buffers in SDRAM and tracks which one the writer fills, which one the display reads, and which one is spare or holds a completed frame.
- On writer frame-end and reader frame-start events it swaps buffers, drives the MIN/MAX address pairs, and pulses WR_LOAD/RD_LOAD to reload the controller's address registers and clear its FIFOs.
- The writer never stalls; the reader always gets the newest complete frame or repeats its current one.

Parameters:
ASIZE, 21, SDRAM word address width (2M x 32).
BUF_BASE, 0, word address of buffer 0.
BUF_STRIDE, 21'h080000, word distance between consecutive buffers.
FRAME_WORDS, 384000, words per frame (800x480); MAX = MIN + FRAME_WORDS.
LOAD_CYCLES, 4, LOAD pulse width in CLK cycles (1..15).

Ports:
CLK  in  1  controller clock, same domain as the SDRAM controller's REF_CLK
RESET  in  1  async active-high reset
WR_FRAME_END  in  1  1-cycle pulse, writer finished the current frame (already synchronous to CLK)
RD_FRAME_START  in  1  1-cycle pulse, display vsync, reader about to start a frame (synchronous to CLK)
WR_LOAD  out  1  write-side load/FIFO clear to the controller
WR_MIN_ADDR  out  ASIZE  write buffer start address
WR_MAX_ADDR  out  ASIZE  write buffer end address
RD_LOAD  out  1  read-side load/FIFO clear to the controller
RD_MIN_ADDR  out  ASIZE  read buffer start address
RD_MAX_ADDR  out  ASIZE  read buffer end address
WR_BUF  out  2  index of the buffer being written
RD_BUF  out  2  index of the buffer being read
FRAME_READY  out  1  spare buffer holds a completed, unread frame
DROP_CNT  out  16  frames overwritten before being read, saturating
REPEAT_CNT  out  16  reader frame starts with no new frame, saturating

Behaviour:
- The state is three 2-bit indices, wr, rd and spare, always a permutation of {0,1,2}, plus a ready flag. Spare is always 3-wr-rd.
- Reset values:
  - wr=0, rd=1, spare=2, ready=0.
  - WR_LOAD=0, RD_LOAD=0; counters=0.
  - Addresses reflect buffers 0 and 1: WR_MIN=BUF_BASE, WR_MAX=BUF_BASE+FRAME_WORDS, RD_MIN=BUF_BASE+BUF_STRIDE, RD_MAX=RD_MIN+FRAME_WORDS.
  - The init flag is set.
- Init: on the first CLK edge after RESET deasserts, the init flag clears and both LOAD counters load LOAD_CYCLES. Both LOADs are high from that edge for LOAD_CYCLES cycles.
- WR_FRAME_END alone:
  - wr and spare swap.
  - If ready was 1, DROP_CNT increments (saturating at FFFF).
  - ready becomes 1.
- RD_FRAME_START alone:
  - If ready=1: rd and spare swap, ready becomes 0.
  - Else: indices are unchanged and REPEAT_CNT increments (saturating).
- Both events in the same cycle are applied in the order write, then read:
  - Result: wr_new=spare_old, rd_new=wr_old, spare_new=rd_old, ready=0.
  - DROP_CNT increments if ready_old=1.
  - REPEAT_CNT does not increment.
- Address outputs are registered and update on the same edge as the index change, computed as MIN=BUF_BASE+idx*BUF_STRIDE (ASIZE arithmetic, truncating) and MAX=MIN+FRAME_WORDS. The multiply is a constant mux over 3 values; no true multiplier.
- LOAD generation:
  - Each side has a 4-bit down-counter; LOAD = (counter != 0), registered.
  - Any event that changes that side's index reloads the counter to LOAD_CYCLES on the same edge. LOAD rises together with the new address, so the address is stable for the whole pulse.
  - A reload during an active pulse extends the pulse: LOAD stays high continuously for LOAD_CYCLES cycles after the last reload.
  - A read repeat (ready=0) also reloads the RD counter, so the read FIFO and address restart at the same buffer.
- WR_BUF, RD_BUF and FRAME_READY are registered copies of wr, rd and ready.
- Events arriving during init or an active LOAD are processed normally; none are lost.
- Invariant: WR_BUF != RD_BUF in every cycle.
- RESET mid-operation: all state returns to the reset values immediately, LOADs drop, and the init sequence repeats after deassertion.

Test Plan:
- Reset release: the first edge after release raises WR_LOAD and RD_LOAD for exactly 4 cycles. WR_MIN=0, WR_MAX=384000, RD_MIN=0x080000, RD_MAX=0x080000+384000.
- WR_FRAME_END, then RD_FRAME_START 10 cycles later:
  - Write: WR_BUF=2, WR_MIN=0x100000, FRAME_READY=1, WR_LOAD high 4 cycles.
  - Read: RD_BUF=0, RD_MIN=0, FRAME_READY=0, RD_LOAD high 4 cycles.
- Two WR_FRAME_END pulses with no read: DROP_CNT=1, WR_BUF returns to 0, FRAME_READY=1.
- RD_FRAME_START with FRAME_READY=0: RD_BUF unchanged, REPEAT_CNT=1, RD_LOAD pulses with the same RD_MIN.
- Simultaneous events from wr=0, rd=1, spare=2, ready=1: wr=2, rd=0, spare=1, FRAME_READY=0, DROP_CNT+1, both LOADs pulse.
- Second WR_FRAME_END 2 cycles into a WR_LOAD pulse: WR_LOAD stays high through 4 cycles after the second event, and the address updates at the second event.
- Assert RESET mid-pulse: LOADs drop immediately and indices return to 0/1/2.
